// File: rtl/program_loader_if.sv
// Byte-stream input, instruction RAM write port and loader status, bundled for the loader.
interface program_loader_if #(
  parameter int unsigned ADDR_W = 8
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] mem_waddr;
  logic [7:0]        mem_wdata;
  logic              mem_we;
  logic              core_run;
  logic              load_busy;
  logic              load_error;

  // Stream source / system side.
  modport master (
    output in_data, in_valid,
    input  in_ready, mem_waddr, mem_wdata, mem_we, core_run, load_busy, load_error
  );

  // Loader side.
  modport slave (
    input  in_data, in_valid,
    output in_ready, mem_waddr, mem_wdata, mem_we, core_run, load_busy, load_error
  );
endinterface

// File: rtl/program_loader.sv
// Program loader: parses SYNC/LEN/payload/CHK frames from a byte stream, writes the payload
// into instruction RAM and lets the core run only after a checksum-verified frame.
module program_loader #(
  parameter int unsigned ADDR_W    = 8,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int unsigned TIMEOUT   = 65535
) (
  input logic              CLK,
  input logic              RESET_N,
  program_loader_if.slave  bus
);

  typedef enum logic [2:0] {StIdle, StLen, StData, StChk, StRun, StErr} state_e;

  localparam int unsigned Depth       = 32'd1 << ADDR_W;
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        sum_q, sum_d;
  logic [15:0]       idle_q, idle_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              ready_q;
  logic              accept;
  logic              is_sync;
  logic              busy;

  assign accept  = bus.in_valid & ready_q;
  assign is_sync = (bus.in_data == SYNC_BYTE);
  assign busy    = (state_q == StLen) || (state_q == StData) || (state_q == StChk);

  // State and datapath registers; everything returns to reset values asynchronously.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= StIdle;
      cnt_q   <= 8'd0;
      addr_q  <= '0;
      sum_q   <= 8'd0;
      idle_q  <= 16'd0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= 8'd0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      sum_q   <= sum_d;
      idle_q  <= idle_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      ready_q <= 1'b1;
    end
  end

  // Frame parser, RAM write generation and inter-byte timeout.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    sum_d   = sum_q;
    idle_d  = 16'd0;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;

    case (state_q)
      StIdle, StRun, StErr: begin
        // A SYNC restarts loading from any resting state; other bytes are dropped.
        if (accept && is_sync) state_d = StLen;
      end
      StLen: begin
        if (accept) begin
          if (bus.in_data == 8'd0 || 32'(bus.in_data) > Depth) begin
            state_d = StErr;
          end else begin
            cnt_d   = bus.in_data;
            addr_d  = '0;
            sum_d   = bus.in_data;
            state_d = StData;
          end
        end
      end
      StData: begin
        // SYNC_BYTE values here are ordinary payload.
        if (accept) begin
          we_d    = 1'b1;
          waddr_d = addr_q;
          wdata_d = bus.in_data;
          addr_d  = addr_q + ADDR_W'(1);
          sum_d   = sum_q + bus.in_data;
          cnt_d   = cnt_q - 8'd1;
          if (cnt_q == 8'd1) state_d = StChk;
        end
      end
      StChk: begin
        if (accept) state_d = (bus.in_data == sum_q) ? StRun : StErr;
      end
      default: state_d = StIdle;
    endcase

    // Idle counter only runs while a frame is open.
    if (busy && !accept) begin
      if (idle_q == TimeoutLast) begin
        state_d = StErr;
      end else begin
        idle_d = idle_q + 16'd1;
      end
    end
  end

  assign bus.in_ready   = ready_q;
  assign bus.mem_we     = we_q;
  assign bus.mem_waddr  = waddr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.core_run   = (state_q == StRun);
  assign bus.load_error = (state_q == StErr);
  assign bus.load_busy  = busy;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: directed frames plus randomized frames, checked against a
// frame-level model (expected RAM image and expected write timing built from each frame).
module tb_program_loader;
  localparam int unsigned AW = 8;
  localparam int unsigned TO = 300;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  program_loader_if #(.ADDR_W(AW)) bus ();

  program_loader #(.ADDR_W(AW), .SYNC_BYTE(8'hA5), .TIMEOUT(TO)) dut (
    .CLK     (clk),
    .RESET_N (rst_n),
    .bus     (bus)
  );

  typedef struct {int c; int a; int d;} wr_t;

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  wr_t  wr_log[$];
  wr_t  wr_exp[$];
  logic [7:0] dut_mem[256];
  logic [7:0] ref_mem[256];

  always @(posedge clk) cyc <= cyc + 1;

  // RAM model on the write port, plus a log of every write with the cycle it was seen.
  always @(posedge clk) begin
    if (bus.mem_we === 1'b1) begin
      wr_log.push_back('{cyc, int'(bus.mem_waddr), int'(bus.mem_wdata)});
      dut_mem[bus.mem_waddr] <= bus.mem_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one byte and wait for its handshake; acc = cycle tag its RAM write must carry.
  task automatic send_byte(input logic [7:0] b, output int acc);
    int w;
    w = 0;
    @(negedge clk);
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    while (bus.in_ready !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (w == 20) check("in_ready_wait", bus.in_ready, 1);
    @(posedge clk);
    #1;
    acc = cyc;
  endtask

  task automatic idle_bus();
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic gap(input int gmax);
    int n;
    n = (gmax > 0) ? int'($urandom_range(gmax)) : 0;
    repeat (n) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
  endtask

  // Whole frame; checksum sent is the correct one plus delta (delta==0 means good frame).
  task automatic send_frame(input logic [7:0] pl[$], input logic [7:0] delta, input int gmax);
    int acc;
    logic [7:0] s;
    s = 8'(pl.size());
    send_byte(8'hA5, acc);
    gap(gmax);
    send_byte(s, acc);
    foreach (pl[i]) begin
      gap(gmax);
      send_byte(pl[i], acc);
      wr_exp.push_back('{acc, i, int'(pl[i])});
      ref_mem[i] = pl[i];
      s = s + pl[i];
    end
    check("pre_chk_run", bus.core_run, 0);
    check("pre_chk_busy", bus.load_busy, 1);
    gap(gmax);
    send_byte(s + delta, acc);
    check("post_chk_run", bus.core_run, (delta == 8'd0));
    check("post_chk_err", bus.load_error, (delta != 8'd0));
    check("post_chk_busy", bus.load_busy, 0);
    idle_bus();
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_nwr"}, wr_log.size(), wr_exp.size());
    for (int i = 0; i < wr_log.size() && i < wr_exp.size(); i++) begin
      check({tag, "_wcyc"}, wr_log[i].c, wr_exp[i].c);
      check({tag, "_waddr"}, wr_log[i].a, wr_exp[i].a);
      check({tag, "_wdata"}, wr_log[i].d, wr_exp[i].d);
    end
    wr_log.delete();
    wr_exp.delete();
  endtask

  task automatic check_mem(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < 256; i++) if (dut_mem[i] !== ref_mem[i]) bad++;
    check({tag, "_mem_bad_entries"}, bad, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, bus.in_ready, 0);
    check({tag, "_we"}, bus.mem_we, 0);
    check({tag, "_waddr"}, bus.mem_waddr, 0);
    check({tag, "_wdata"}, bus.mem_wdata, 0);
    check({tag, "_run"}, bus.core_run, 0);
    check({tag, "_busy"}, bus.load_busy, 0);
    check({tag, "_err"}, bus.load_error, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pl[$];
    int acc;
    int len;

    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    for (int i = 0; i < 256; i++) begin
      dut_mem[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end

    // Reset values while reset is held.
    #1;
    check_reset_outputs("rst");
    #20 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_release_ready", bus.in_ready, 1);

    // 1: idle stream.
    repeat (100) @(posedge clk);
    #1;
    check("idle_nwr", wr_log.size(), 0);
    check("idle_run", bus.core_run, 0);
    check("idle_ready", bus.in_ready, 1);
    check("idle_busy", bus.load_busy, 0);

    // 2: A5 03 00 03 02 08.
    pl = '{8'h00, 8'h03, 8'h02};
    send_frame(pl, 8'd0, 0);
    check_writes("t2");
    check_mem("t2");

    // 3: A5 02 11 22 00 (correct CHK is 35).
    pl = '{8'h11, 8'h22};
    send_frame(pl, 8'h00 - 8'h35, 0);
    check_writes("t3");
    check_mem("t3");
    send_byte(8'hA5, acc);
    check("t3_sync_clears_err", bus.load_error, 0);
    check("t3_sync_busy", bus.load_busy, 1);
    // Zero length is rejected with no writes.
    send_byte(8'h00, acc);
    idle_bus();
    check("t3_len0_err", bus.load_error, 1);
    check("t3_len0_busy", bus.load_busy, 0);
    check_writes("t3_len0");

    // 4: garbage, then a frame whose payload is the SYNC value.
    send_byte(8'h3C, acc);
    send_byte(8'hFF, acc);
    check("t4_garbage_busy", bus.load_busy, 0);
    pl = '{8'hA5};
    send_frame(pl, 8'd0, 0);
    check_writes("t4");
    check_mem("t4");

    // 5: reload from RUN, then stall mid-frame until the timeout fires.
    send_byte(8'hA5, acc);
    check("t5_sync_stops_core", bus.core_run, 0);
    send_byte(8'h04, acc);
    send_byte(8'h01, acc);
    wr_exp.push_back('{acc, 0, 1});
    ref_mem[0] = 8'h01;
    idle_bus();
    repeat (TO - 1) @(posedge clk);
    #1;
    check("t5_before_timeout_busy", bus.load_busy, 1);
    check("t5_before_timeout_err", bus.load_error, 0);
    @(posedge clk);
    #1;
    check("t5_timeout_busy", bus.load_busy, 0);
    check("t5_timeout_err", bus.load_error, 1);
    check("t5_timeout_run", bus.core_run, 0);
    check_writes("t5");
    check_mem("t5");

    // Randomized frames with interleaved garbage and idle gaps.
    for (int k = 0; k < 25; k++) begin
      repeat ($urandom_range(2)) begin
        send_byte(8'($urandom_range(8'hA4)), acc);
      end
      len = (k == 7) ? 255 : int'($urandom_range(40, 1));
      pl.delete();
      for (int i = 0; i < len; i++) begin
        pl.push_back(($urandom_range(3) == 0) ? 8'hA5 : 8'($urandom));
      end
      send_frame(pl, ($urandom_range(3) == 0) ? 8'($urandom_range(255, 1)) : 8'd0, 2);
      check_writes("rnd");
      check_mem("rnd");
    end

    // 6: running core, reload, async reset mid-DATA.
    pl = '{8'h10, 8'h20};
    send_frame(pl, 8'd0, 0);
    check_writes("t6_pre");
    send_byte(8'hA5, acc);
    check("t6_sync_run", bus.core_run, 0);
    check("t6_sync_busy", bus.load_busy, 1);
    send_byte(8'h05, acc);
    send_byte(8'h5E, acc);
    wr_exp.push_back('{acc, 0, 32'h5E});
    ref_mem[0] = 8'h5E;
    send_byte(8'h6F, acc);
    wr_exp.push_back('{acc, 1, 32'h6F});
    ref_mem[1] = 8'h6F;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_reset_outputs("t6_rst");
    #20 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("t6_release_ready", bus.in_ready, 1);
    check("t6_release_run", bus.core_run, 0);
    check_writes("t6");
    check_mem("t6");
    pl = '{8'h42, 8'h43, 8'h44};
    send_frame(pl, 8'd0, 1);
    check_writes("t6_post");
    check_mem("t6_post");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
